// File: rtl/gs_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// gs_butterfly_pipe
//
// Pipelined Gentleman-Sande butterfly for the Kyber inverse NTT (q = 3329).
// For every accepted operand pair it produces:
//   out_a = (a + b) mod q
//   out_b = ((a - b) mod q) * zeta mod q
// It sits between the coefficient RAM read port and the write-back port.
// Three register stages (S1 add/sub, S2 multiply, S3 Barrett reduction) give
// a three-cycle latency and one pair per cycle throughput. Stalls propagate
// backwards through per-stage advance terms, so bubbles collapse.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  operand pair valid
//   in_ready  block accepts the pair this cycle
//   in_a      coefficient a (< q)
//   in_b      coefficient b (< q)
//   in_zeta   twiddle factor (< q)
//   in_tag    opaque tag, carried through for write-back addressing
//   out_valid result valid; result holds until out_ready
//   out_ready downstream accepts the result
//   out_a     (a + b) mod q
//   out_b     ((a - b) mod q * zeta) mod q
//   out_tag   tag belonging to this result
// -----------------------------------------------------------------------------
module gs_butterfly_pipe #(
    parameter int TAG_W     = 8,
    parameter int BARRETT_M = 5039
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [15:0]      in_zeta,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_a,
    output logic [15:0]      out_b,
    output logic [TAG_W-1:0] out_tag
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 12;
    localparam logic [DATA_W-1:0] Q    = 16'd3329;
    localparam logic [36:0]       M_37 = 37'(BARRETT_M);

    // (a + b) mod q for operands already in [0, q).
    function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) begin
            s = s - {1'b0, Q};
        end
        return s[DATA_W-1:0];
    endfunction

    // (a - b) mod q for operands already in [0, q).
    function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a + Q - b;
        end
        return d;
    endfunction

    // Barrett reduction of a 24-bit product. The quotient estimate t is at
    // most one short of floor(p / q), so the 14-bit remainder is below 2q and
    // a single conditional subtraction lands it in [0, q).
    function automatic logic [DATA_W-1:0] barrett_reduce(input logic [23:0] p);
        logic [36:0] pm;
        logic [12:0] t;
        logic [23:0] tq;
        logic [13:0] r;
        pm = {13'd0, p} * M_37;
        t  = pm[36:24];
        tq = {11'd0, t} * {8'd0, Q};
        r  = 14'(p - tq);
        if (r >= 14'(Q)) begin
            r = r - 14'(Q);
        end
        return {2'b00, r};
    endfunction

    logic              vld_p1, vld_p2, vld_p3;
    logic              adv1, adv2, adv3;
    logic              accept;

    logic [DATA_W-1:0] sum_p1, diff_p1, zeta_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [DATA_W-1:0] sum_p2;
    logic [23:0]       prod_p2;
    logic [TAG_W-1:0]  tag_p2;

    // Only the low COEF_W bits feed the multiplier; for in-range operands the
    // upper bits are always zero and are dropped deliberately.
    logic              unused_hi_bits;
    assign unused_hi_bits = ^{diff_p1[DATA_W-1:COEF_W], zeta_p1[DATA_W-1:COEF_W]};

    // A stage may load when it is empty or when the stage after it moves.
    assign adv3     = !vld_p3 || out_ready;
    assign adv2     = !vld_p2 || adv3;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && in_ready;

    assign out_valid = vld_p3;

    // Stage valids and the output registers; these carry reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            out_a   <= '0;
            out_b   <= '0;
            out_tag <= '0;
        end else begin
            if (adv1) begin
                vld_p1 <= accept;
            end
            if (adv2) begin
                vld_p2 <= vld_p1;
            end
            if (adv3) begin
                vld_p3 <= vld_p2;
            end
            // S2 -> S3: Barrett reduction, S3 drives the out_* ports
            if (adv3 && vld_p2) begin
                out_a   <= sum_p2;
                out_b   <= barrett_reduce(prod_p2);
                out_tag <= tag_p2;
            end
        end
    end

    // input -> S1: modular sum and difference
    always_ff @(posedge clk) begin
        if (accept) begin
            sum_p1  <= mod_add(in_a, in_b);
            diff_p1 <= mod_sub(in_a, in_b);
            zeta_p1 <= in_zeta;
            tag_p1  <= in_tag;
        end
    end

    // S1 -> S2: 12x12 product, sum and tag delayed
    always_ff @(posedge clk) begin
        if (adv2 && vld_p1) begin
            prod_p2 <= {12'd0, diff_p1[COEF_W-1:0]} * {12'd0, zeta_p1[COEF_W-1:0]};
            sum_p2  <= sum_p1;
            tag_p2  <= tag_p1;
        end
    end

endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// tb_gs_butterfly_pipe
//
// Self-checking bench for gs_butterfly_pipe. A queue of expected results is
// built from plain modular arithmetic on every accepted pair and compared in
// order against every emitted result. Directed cases cover latency, wrap on
// subtraction, the maximum product, capacity, stalls and reset; a long random
// run mixes in_valid and out_ready.
// -----------------------------------------------------------------------------
module tb_gs_butterfly_pipe;

    localparam int TAG_W = 8;
    localparam int Q     = 3329;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a, in_b, in_zeta;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_a, out_b;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    gs_butterfly_pipe #(
        .TAG_W     (TAG_W),
        .BARRETT_M (5039)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_zeta   (in_zeta),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_tag   (out_tag)
    );

    typedef struct {
        int a;
        int b;
        int tag;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    bit          acc_last;
    bit          held_v = 1'b0;
    logic [63:0] held_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_a(input int a, input int b);
        return (a + b) % Q;
    endfunction

    function automatic int ref_b(input int a, input int b, input int z);
        return (((a - b) + Q) % Q) * z % Q;
    endfunction

    // One clock cycle: drive inputs on the falling edge, then settle and
    // score both handshakes that the next rising edge will perform.
    task automatic cycle(input bit v, input int a, input int b, input int z,
                         input int tg, input bit ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = 16'(a);
        in_b      = 16'(b);
        in_zeta   = 16'(z);
        in_tag    = TAG_W'(tg);
        out_ready = ordy;
        #1;
        if (held_v) begin
            check("hold_stable", {23'd0, out_valid, out_tag, out_a, out_b}, held_data);
        end
        held_v    = out_valid && !out_ready;
        held_data = {23'd0, out_valid, out_tag, out_a, out_b};
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_a", 64'(out_a), 64'(e.a));
                check("out_b", 64'(out_b), 64'(e.b));
                check("out_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        acc_last = in_valid && in_ready;
        if (acc_last) begin
            exp_q.push_back('{ref_a(a, b), ref_b(a, b, z), tg & 255});
        end
    endtask

    // Single pair into an empty pipe with out_ready high: checks acceptance,
    // latency and the hand-computed result.
    task automatic run_one(input int a, input int b, input int z, input int tg,
                           input int ea, input int eb, input string nm);
        int  n;
        bit  got;
        cycle(1'b1, a, b, z, tg, 1'b1);
        check({nm, "_acc"}, 64'(acc_last), 64'd1);
        got = 1'b0;
        n   = 1;
        while (!got && n <= 10) begin
            cycle(1'b0, 0, 0, 0, 0, 1'b1);
            if (out_valid) got = 1'b1;
            else n++;
        end
        check({nm, "_lat"}, 64'(n), 64'd3);
        check({nm, "_a"}, 64'(out_a), 64'(ea));
        check({nm, "_b"}, 64'(out_b), 64'(eb));
        check({nm, "_tag"}, 64'(out_tag), 64'(tg & 255));
    endtask

    initial begin
        int n_acc;
        int nxt;
        int c;
        int base;
        int ca, cb, cz;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_zeta   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_a", 64'(out_a), 64'd0);
        check("rst_out_b", 64'(out_b), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_one(5, 3, 1, 8'h11, 8, 2, "t1");
        run_one(3, 5, 1, 8'h22, 8, 3327, "t2");
        run_one(1000, 2500, 17, 8'h33, 171, 1132, "t3");
        run_one(3328, 0, 3328, 8'h44, 3328, 1, "t4");

        // Capacity: with nothing drained, exactly three pairs get in.
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 100 + i, 7 * i, 3 + i, 8'h50 + i, 1'b0);
            if (acc_last) n_acc++;
        end
        check("cap_acc", 64'(n_acc), 64'd3);
        check("cap_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle(1'b0, 0, 0, 0, 0, 1'b1);
        end
        check("cap_drain", 64'(exp_q.size()), 64'd0);

        // Tags 0..9 back to back, downstream stalled during cycles 4..8.
        base = n_out;
        nxt  = 0;
        c    = 0;
        ca   = $urandom_range(0, Q - 1);
        cb   = $urandom_range(0, Q - 1);
        cz   = $urandom_range(0, Q - 1);
        while ((nxt < 10 || exp_q.size() != 0) && c < 100) begin
            cycle(nxt < 10, ca, cb, cz, nxt, !(c >= 4 && c <= 8));
            if (c >= 4 && c <= 8) check("s5_in_ready_low", 64'(in_ready), 64'd0);
            if (acc_last) begin
                nxt++;
                ca = $urandom_range(0, Q - 1);
                cb = $urandom_range(0, Q - 1);
                cz = $urandom_range(0, Q - 1);
            end
            c++;
        end
        check("s5_count", 64'(n_out - base), 64'd10);
        check("s5_empty", 64'(exp_q.size()), 64'd0);

        // Long random run with random valid and ready.
        base = n_out;
        nxt  = 0;
        c    = 0;
        while ((nxt < 10000 || exp_q.size() != 0) && c < 60000) begin
            cycle((nxt < 10000) && ($urandom_range(0, 3) != 0),
                  $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                  $urandom_range(0, Q - 1), nxt, $urandom_range(0, 3) != 0);
            if (acc_last) nxt++;
            c++;
        end
        check("rnd_count", 64'(n_out - base), 64'd10000);
        check("rnd_empty", 64'(exp_q.size()), 64'd0);

        // Reset with two pairs in flight; an offered pair during reset is ignored.
        cycle(1'b1, 10, 20, 30, 8'hA1, 1'b0);
        cycle(1'b1, 40, 50, 60, 8'hA2, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'd7;
        in_b      = 16'd9;
        in_zeta   = 16'd11;
        in_tag    = 8'hA3;
        out_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("r6_out_valid", 64'(out_valid), 64'd0);
        check("r6_out_a", 64'(out_a), 64'd0);
        check("r6_out_b", 64'(out_b), 64'd0);
        check("r6_out_tag", 64'(out_tag), 64'd0);
        check("r6_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        held_v = 1'b0;
        base   = n_out;
        repeat (6) cycle(1'b0, 0, 0, 0, 0, 1'b1);
        check("r6_no_stale", 64'(n_out - base), 64'd0);
        run_one(1, 1, 2, 8'h5A, 2, 0, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
